// File: rtl/fetch_issue_unit.sv
// Front end of the RV32I OoO core: PC generation, icache fetch, fetch queue and issue.
// Optional BRANCH_PREDICT_EN makes branch next-PC and issuePredJump follow the predictor.
//
// state      | meaning
// FETCH      | requesting words at pc_q while the queue has room
// WAIT_JALR  | JALR fetched, holding PC until the target is resolved
module fetch_issue_unit #(
    parameter int          ROB_WIDTH = 4,
    parameter int          FQ_WIDTH  = 3,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    output logic                 fetchReq,
    output logic [31:0]          fetchAddr,
    input  logic                 instrInValid,
    input  logic [31:0]          instrIn,
    input  logic [31:0]          instrAddr,
    input  logic                 jump,
    input  logic                 jalrValid,
    input  logic [31:0]          jalrTarget,
    input  logic                 flushValid,
    input  logic [31:0]          flushAddr,
    input  logic                 robFull,
    input  logic                 rsFull,
    input  logic                 lsbFull,
    input  logic [ROB_WIDTH-1:0] robNext,
    output logic                 issueValid,
    output logic [31:0]          issueInstr,
    output logic [31:0]          issueAddr,
    output logic                 issuePredJump,
    output logic [1:0]           issueUnit,
    output logic [ROB_WIDTH-1:0] issueRobIndex
);

    localparam int               DEPTH   = 1 << FQ_WIDTH;
    localparam logic [FQ_WIDTH:0] DEPTH_C = (FQ_WIDTH+1)'(DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic {
        S_FETCH,
        S_WAIT_JALR
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [FQ_WIDTH-1:0]   head_q, head_d;
    logic [FQ_WIDTH-1:0]   tail_q, tail_d;
    logic [FQ_WIDTH:0]     count_q, count_d;

    logic [31:0]           fq_instr_q [DEPTH];
    logic [31:0]           fq_addr_q  [DEPTH];
    logic                  fq_pred_q  [DEPTH];

    logic                  push;
    logic [6:0]            in_opcode;
    logic [31:0]           j_imm;
    logic [31:0]           b_imm;
    logic                  pred_in;
    logic [6:0]            head_opcode;
    logic [1:0]            unit;

    assign fetchReq  = (state_q == S_FETCH) & (count_q < DEPTH_C) & ~flushValid & ~resetIn;
    assign fetchAddr = pc_q;

    // Responses for any other address are stale (issued before a redirect) and dropped.
    assign push = fetchReq & instrInValid & (instrAddr == pc_q);

    assign in_opcode = instrIn[6:0];
    assign j_imm = {{11{instrIn[31]}}, instrIn[31], instrIn[19:12], instrIn[20],
                    instrIn[30:21], 1'b0};
    assign b_imm = {{19{instrIn[31]}}, instrIn[31], instrIn[7], instrIn[30:25],
                    instrIn[11:8], 1'b0};

`ifdef BRANCH_PREDICT_EN
    assign pred_in = jump & (in_opcode == OP_BRANCH);
`else
    logic unused_jump;
    assign unused_jump = jump;
    assign pred_in     = 1'b0;
`endif

    assign issueInstr  = fq_instr_q[head_q];
    assign issueAddr   = fq_addr_q[head_q];
    assign head_opcode = issueInstr[6:0];

    always_comb begin
        unit = 2'd0;
        case (head_opcode)
            OP_ALU, OP_ALUI:  unit = 2'd1;
            OP_LOAD, OP_STORE: unit = 2'd2;
            default:          unit = 2'd0;
        endcase
    end

    assign issueUnit     = unit;
    assign issueRobIndex = robNext;
    assign issuePredJump = (count_q != '0) & fq_pred_q[head_q];
    assign issueValid    = (count_q != '0) & ~robFull
                         & ~((unit == 2'd1) & rsFull)
                         & ~((unit == 2'd2) & lsbFull)
                         & ~flushValid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flushValid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = flushAddr;
            state_d = S_FETCH;
        end else begin
            if (push) begin
                tail_d = tail_q + FQ_WIDTH'(1);
            end
            if (issueValid) begin
                head_d = head_q + FQ_WIDTH'(1);
            end
            case ({push, issueValid})
                2'b10:   count_d = count_q + (FQ_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (FQ_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                S_FETCH: begin
                    if (push) begin
                        case (in_opcode)
                            OP_JAL:    pc_d = pc_q + j_imm;
                            OP_BRANCH: pc_d = pred_in ? (pc_q + b_imm) : (pc_q + 32'd4);
                            OP_JALR:   state_d = S_WAIT_JALR;
                            default:   pc_d = pc_q + 32'd4;
                        endcase
                    end
                end
                S_WAIT_JALR: begin
                    if (jalrValid) begin
                        pc_d    = jalrTarget;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clockIn) begin
        if (push) begin
            fq_instr_q[tail_q] <= instrIn;
            fq_addr_q[tail_q]  <= pc_q;
            fq_pred_q[tail_q]  <= pred_in;
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Self-checking bench for fetch_issue_unit: directed scenarios then randomized traffic,
// all compared against a queue-based reference model of the fetch/issue rules.
module tb_fetch_issue_unit;

    localparam int          ROBW  = 4;
    localparam int          FQW   = 2;
    localparam int          DEPTH = 1 << FQW;
    localparam logic [31:0] RPC   = 32'h0;

    localparam logic [31:0] W_ADDI   = 32'h00100093;
    localparam logic [31:0] W_JAL20  = 32'h0200006F;
    localparam logic [31:0] W_JALR   = 32'h00008067;
    localparam logic [31:0] W_BEQ8   = 32'h00000463;

    logic            clockIn, resetIn;
    logic            fetchReq;
    logic [31:0]     fetchAddr;
    logic            instrInValid;
    logic [31:0]     instrIn, instrAddr;
    logic            jump, jalrValid;
    logic [31:0]     jalrTarget;
    logic            flushValid;
    logic [31:0]     flushAddr;
    logic            robFull, rsFull, lsbFull;
    logic [ROBW-1:0] robNext;
    logic            issueValid;
    logic [31:0]     issueInstr, issueAddr;
    logic            issuePredJump;
    logic [1:0]      issueUnit;
    logic [ROBW-1:0] issueRobIndex;

    fetch_issue_unit #(.ROB_WIDTH(ROBW), .FQ_WIDTH(FQW), .RESET_PC(RPC)) dut (
        .clockIn(clockIn), .resetIn(resetIn),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr),
        .instrInValid(instrInValid), .instrIn(instrIn), .instrAddr(instrAddr),
        .jump(jump), .jalrValid(jalrValid), .jalrTarget(jalrTarget),
        .flushValid(flushValid), .flushAddr(flushAddr),
        .robFull(robFull), .rsFull(rsFull), .lsbFull(lsbFull), .robNext(robNext),
        .issueValid(issueValid), .issueInstr(issueInstr), .issueAddr(issueAddr),
        .issuePredJump(issuePredJump), .issueUnit(issueUnit), .issueRobIndex(issueRobIndex)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_wait;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] unit_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110011, 7'b0010011: return 2'd1;
            7'b0000011, 7'b0100011: return 2'd2;
            default:                return 2'd0;
        endcase
    endfunction

    function automatic logic pred_of(input logic [31:0] w, input logic j);
`ifdef BRANCH_PREDICT_EN
        return j && (w[6:0] == 7'b1100011);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w,
                                            input logic p);
        int jimm, bimm;
        jimm = ($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
        bimm = ($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
        case (w[6:0])
            7'b1101111: return pc + 32'(jimm);
            7'b1100011: return p ? pc + 32'(bimm) : pc + 32'd4;
            default:    return pc + 32'd4;
        endcase
    endfunction

    // One clock: check outputs against the model, clock the DUT, advance the model.
    task automatic cycle();
        bit          e_req, e_acc, e_iss, pj;
        logic [1:0]  u;
        ent_t        h;
        #1;
        e_req = !m_wait && (mq.size() < DEPTH) && !flushValid;
        e_acc = e_req && instrInValid && (instrAddr == m_pc);
        e_iss = 1'b0;
        check("fetchReq", fetchReq, e_req);
        check("fetchAddr", fetchAddr, m_pc);
        if (mq.size() > 0) begin
            h = mq[0];
            u = unit_of(h.instr);
            e_iss = !robFull && !(u == 2'd1 && rsFull) && !(u == 2'd2 && lsbFull) && !flushValid;
            check("issueInstr", issueInstr, h.instr);
            check("issueAddr", issueAddr, h.addr);
            check("issueUnit", issueUnit, u);
            check("issuePredJump", issuePredJump, h.pred);
            check("issueRobIndex", issueRobIndex, robNext);
        end
        check("issueValid", issueValid, e_iss);
        @(posedge clockIn);
        if (flushValid) begin
            mq.delete();
            m_pc   = flushAddr;
            m_wait = 0;
        end else begin
            if (e_iss) void'(mq.pop_front());
            if (e_acc) begin
                pj = pred_of(instrIn, jump);
                mq.push_back('{instr: instrIn, addr: m_pc, pred: pj});
                if (instrIn[6:0] == 7'b1100111) m_wait = 1;
                else m_pc = next_pc(m_pc, instrIn, pj);
            end else if (m_wait && jalrValid) begin
                m_pc   = jalrTarget;
                m_wait = 0;
            end
        end
        @(negedge clockIn);
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h10:  return W_JAL20;
            32'h30:  return W_JALR;
            32'h50:  return W_BEQ8;
            default: return W_ADDI;
        endcase
    endfunction

    task automatic quiet();
        instrInValid = 0; instrIn = '0; instrAddr = '0; jump = 0;
        jalrValid = 0; jalrTarget = '0; flushValid = 0; flushAddr = '0;
        robFull = 0; rsFull = 0; lsbFull = 0; robNext = '0;
    endtask

    task automatic feed();
        instrInValid = 1;
        instrAddr    = m_pc;
        instrIn      = rom(m_pc);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 8))
            0:       op = 7'b0010011;
            1:       op = 7'b0110011;
            2:       op = 7'b0000011;
            3:       op = 7'b0100011;
            4:       op = 7'b1101111;
            5:       op = 7'b1100011;
            6:       op = 7'b1100111;
            7:       op = 7'b0110111;
            default: op = r[6:0];
        endcase
        return {r[31:7], op};
    endfunction

    initial begin
        quiet();
        resetIn = 1;
        m_pc = RPC; m_wait = 0;
        @(posedge clockIn);
        @(posedge clockIn);
        @(negedge clockIn);
        check("rst_fetchReq", fetchReq, 1'b0);
        check("rst_issueValid", issueValid, 1'b0);
        check("rst_fetchAddr", fetchAddr, RPC);
        check("rst_issuePredJump", issuePredJump, 1'b0);
        resetIn = 0;

        // sequential ADDIs then JAL at 0x10 (+0x20)
        for (int i = 0; i < 5; i++) begin feed(); cycle(); end
        #1 check("jal_target", fetchAddr, 32'h30);

        // JALR at 0x30, target resolved a few cycles later
        feed(); cycle();
        for (int i = 0; i < 3; i++) begin
            feed();
            #1 check("jalr_wait_req", fetchReq, 1'b0);
            cycle();
        end
        jalrValid = 1; jalrTarget = 32'h100; cycle();
        jalrValid = 0;
        #1 check("jalr_target", fetchAddr, 32'h100);

        // redirect to a predicted-taken branch at 0x50
        flushValid = 1; flushAddr = 32'h50; cycle();
        flushValid = 0;
        jump = 1; feed(); cycle(); jump = 0;
`ifdef BRANCH_PREDICT_EN
        #1 check("branch_target", fetchAddr, 32'h58);
`else
        #1 check("branch_target", fetchAddr, 32'h54);
`endif
        for (int i = 0; i < 3; i++) begin feed(); cycle(); end

        // fill the queue behind a full ROB, then drain
        robFull = 1;
        for (int i = 0; i < 6; i++) begin feed(); cycle(); end
        feed();
        #1 check("full_fetchReq", fetchReq, 1'b0);
        robFull = 0;
        for (int i = 0; i < 6; i++) begin feed(); cycle(); end

        // flush with entries queued and a simultaneous jalrValid
        robFull = 1;
        for (int i = 0; i < 3; i++) begin feed(); cycle(); end
        flushValid = 1; flushAddr = 32'h200; jalrValid = 1; jalrTarget = 32'h300; cycle();
        quiet();
        #1 check("flush_fetchAddr", fetchAddr, 32'h200);
        check("flush_issueValid", issueValid, 1'b0);
        check("flush_fetchReq", fetchReq, 1'b1);
        cycle();

        for (int n = 0; n < 3000; n++) begin
            instrInValid = ($urandom_range(0, 3) != 0);
            instrAddr    = ($urandom_range(0, 4) == 0) ? m_pc + 32'd4 : m_pc;
            instrIn      = rand_instr();
            jump         = 1'($urandom());
            jalrValid    = ($urandom_range(0, 3) == 0);
            jalrTarget   = $urandom() & 32'hFFFF_FFFC;
            flushValid   = ($urandom_range(0, 40) == 0);
            flushAddr    = $urandom() & 32'hFFFF_FFFC;
            robFull      = ($urandom_range(0, 3) == 0);
            rsFull       = ($urandom_range(0, 3) == 0);
            lsbFull      = ($urandom_range(0, 3) == 0);
            robNext      = ROBW'($urandom());
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
